// File: rtl/mips_pkg.sv
// Shared MIPS32 fetch types: memory geometry, fetch FSM states and the
// {pc, instr} entry carried from fetch to decode.
package mips_pkg;

  localparam int unsigned IMEM_BYTES = 1024;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Word-aligned and the whole word lies inside memory; 33-bit sum so a
  // pc near 2^32 cannot wrap into the legal range.
  function automatic logic fetch_legal(input logic [31:0] addr,
                                       input int unsigned mem_bytes);
    logic [32:0] last;
    last = {1'b0, addr} + 33'd3;
    return (addr[1:0] == 2'b00) && (last < 33'(mem_bytes));
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch FIFO of fetch entries with flush; push and pop may coincide when
// full. Head reads as zero while empty.
module ifetch_fifo
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign dout  = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // When full, push+pop writes the slot being vacated by the head this edge.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// MIPS32 instruction fetch controller: pc, prefetch FIFO, redirect/flush and
// fetch-address trapping. IFETCH_PERF_EN adds fetch/stall/flush counters.
module ifetch_ctrl
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned MEM_BYTES  = IMEM_BYTES,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [31:0] fault_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flush
`endif
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic         pc_legal;
  logic         redir_legal;
  logic         full;
  logic         empty;
  logic         push;
  logic         pop;
  fetch_entry_t push_entry;
  fetch_entry_t head;

  assign pc_legal    = fetch_legal(pc, MEM_BYTES);
  assign redir_legal = fetch_legal(redirect_pc, MEM_BYTES);

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign push      = (state == FETCH) && pc_legal && (!full || pop) && !redirect_valid;

  assign imem_addr  = pc;
  assign push_entry = '{pc: pc, instr: imem_data};
  assign out_pc     = head.pc;
  assign out_instr  = head.instr;
  assign fault      = (state == FAULT);

  ifetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop && !redirect_valid),
    .din   (push_entry),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      fault_pc <= '0;
    end else if (redirect_valid) begin
      if (redir_legal) begin
        state <= FETCH;
        pc    <= redirect_pc;
      end else begin
        state    <= FAULT;
        fault_pc <= redirect_pc;
      end
    end else if (state == FETCH) begin
      if (!pc_legal) begin
        state    <= FAULT;
        fault_pc <= pc;
      end else if (push) begin
        pc <= pc + 32'(WORD_BYTES);
      end
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
      perf_flush   <= '0;
    end else begin
      if (push) perf_fetched <= perf_fetched + 32'd1;
      if ((state == FETCH) && pc_legal && full && !pop) perf_stall <= perf_stall + 32'd1;
      if (redirect_valid) perf_flush <= perf_flush + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: queue-based fetch model compared every
// cycle, plus literal expectations for the directed scenarios.
module tb_ifetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          MEMB     = 1024;
  localparam int          DEPTH    = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;
  logic [31:0] fault_pc;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
  logic [31:0] perf_flush;
`endif

  logic [7:0]  mem [MEMB];

  int          checks   = 0;
  int          failures = 0;

  beat_t       mq [$];
  logic [31:0] mpc;
  logic        mflt;
  logic [31:0] mfpc;
  int          mn;
  bit          mpop;
  bit          mpush;
  logic [31:0] log_pc [$];

  ifetch_ctrl #(
    .RESET_PC   (RESET_PC),
    .MEM_BYTES  (MEMB),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fault          (fault),
    .fault_pc       (fault_pc)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall),
    .perf_flush     (perf_flush)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rdword(input logic [31:0] a);
    if (a > 32'(MEMB - 4)) return 32'h0;
    return {mem[a], mem[a + 1], mem[a + 2], mem[a + 3]};
  endfunction

  assign imem_data = rdword(imem_addr);

  function automatic bit mlegal(input logic [31:0] a);
    longint unsigned v;
    v = longint'(a);
    return (v % 4 == 0) && (v + 3 < longint'(MEMB));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic setword(input int addr, input logic [31:0] w);
    mem[addr]     = w[31:24];
    mem[addr + 1] = w[23:16];
    mem[addr + 2] = w[15:8];
    mem[addr + 3] = w[7:0];
  endtask

  // Reference: FIFO occupancy as a queue, fault as a flag.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      mpc  = RESET_PC;
      mflt = 1'b0;
      mfpc = '0;
    end else begin
      mn   = mq.size();
      mpop = (mn > 0) && out_ready;
      if (redirect_valid) begin
        mq.delete();
        if (mlegal(redirect_pc)) begin
          mpc  = redirect_pc;
          mflt = 1'b0;
        end else begin
          mflt = 1'b1;
          mfpc = redirect_pc;
        end
      end else begin
        mpush = !mflt && mlegal(mpc) && (mn < DEPTH || mpop);
        if (!mflt && !mlegal(mpc)) begin
          mflt = 1'b1;
          mfpc = mpc;
        end
        if (mpop) void'(mq.pop_front());
        if (mpush) begin
          mq.push_back({mpc, rdword(mpc)});
          mpc = mpc + 32'd4;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("out_valid", {31'b0, out_valid}, {31'b0, mq.size() > 0});
    chk("out_pc", out_pc, (mq.size() > 0) ? mq[0].pc : 32'h0);
    chk("out_instr", out_instr, (mq.size() > 0) ? mq[0].instr : 32'h0);
    chk("imem_addr", imem_addr, mpc);
    chk("fault", {31'b0, fault}, {31'b0, mflt});
    chk("fault_pc", fault_pc, mfpc);
    if (!reset && out_valid && out_ready) log_pc.push_back(out_pc);
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    cyc(1);
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < MEMB; i += 4) setword(i, 32'hC000_0000 | 32'(i));
    setword(0,  32'h2008_0005);
    setword(4,  32'h2009_0003);
    setword(8,  32'h0109_5020);
    setword(12, 32'h0000_0000);

    reset          = 1'b1;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    cyc(3);
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_fault", {31'b0, fault}, 32'h0);
    chk("rst_fault_pc", fault_pc, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);

    // 1: streaming after reset
    out_ready = 1'b1;
    reset     = 1'b0;
    log_pc.delete();
    cyc(1);
    chk("t1_first_valid", {31'b0, out_valid}, 32'h1);
    chk("t1_first_pc", out_pc, 32'h0);
    chk("t1_first_instr", out_instr, 32'h2008_0005);
    cyc(3);
    chk("t1_beats", 32'(log_pc.size()), 32'd3);
    chk("t1_pc0", log_pc[0], 32'h00);
    chk("t1_pc1", log_pc[1], 32'h04);
    chk("t1_pc2", log_pc[2], 32'h08);

    // 2: backpressure fills the FIFO
    out_ready = 1'b0;
    do_reset();
    cyc(5);
    chk("t2_addr_hold", imem_addr, 32'h08);
    chk("t2_head", out_pc, 32'h00);
    log_pc.delete();
    out_ready = 1'b1;
    cyc(3);
    chk("t2_beats", 32'(log_pc.size()), 32'd3);
    chk("t2_pc0", log_pc[0], 32'h00);
    chk("t2_pc1", log_pc[1], 32'h04);
    chk("t2_pc2", log_pc[2], 32'h08);

    // 3: redirect while full, handshake in the same cycle
    out_ready = 1'b0;
    do_reset();
    cyc(4);
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    cyc(1);
    redirect_valid = 1'b0;
    log_pc.delete();
    chk("t3_flushed", {31'b0, out_valid}, 32'h0);
    cyc(3);
    chk("t3_beats", 32'(log_pc.size()), 32'd2);
    chk("t3_pc0", log_pc[0], 32'h10);
    chk("t3_pc1", log_pc[1], 32'h14);

    // 4: misaligned redirect, then recovery
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    cyc(1);
    redirect_valid = 1'b0;
    chk("t4_fault", {31'b0, fault}, 32'h1);
    chk("t4_fault_pc", fault_pc, 32'h102);
    cyc(3);
    chk("t4_no_push", {31'b0, out_valid}, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    cyc(1);
    redirect_valid = 1'b0;
    chk("t4_fault_clr", {31'b0, fault}, 32'h0);
    chk("t4_fault_pc_hold", fault_pc, 32'h102);
    chk("t4_addr", imem_addr, 32'h0);
    log_pc.delete();
    cyc(2);
    chk("t4_resume", log_pc[0], 32'h0);

    // 5: run off the end of memory
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3F8;
    cyc(1);
    redirect_valid = 1'b0;
    log_pc.delete();
    cyc(6);
    chk("t5_beats", 32'(log_pc.size()), 32'd2);
    chk("t5_pc0", log_pc[0], 32'h3F8);
    chk("t5_pc1", log_pc[1], 32'h3FC);
    chk("t5_fault", {31'b0, fault}, 32'h1);
    chk("t5_fault_pc", fault_pc, 32'h400);

    // 6: asynchronous reset mid-stream
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    cyc(1);
    redirect_valid = 1'b0;
    cyc(3);
    chk("t6_streaming", {31'b0, out_valid}, 32'h1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t6_valid", {31'b0, out_valid}, 32'h0);
    chk("t6_addr", imem_addr, RESET_PC);
    chk("t6_fault", {31'b0, fault}, 32'h0);
`ifdef IFETCH_PERF_EN
    chk("t6_perf_fetched", perf_fetched, 32'h0);
    chk("t6_perf_stall", perf_stall, 32'h0);
    chk("t6_perf_flush", perf_flush, 32'h0);
`endif
    cyc(2);
    reset = 1'b0;
    cyc(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
Instruction fetch controller for the MIPS32 core. Owns the program counter, drives the byte-addressed, big-endian, combinational instruction memory and buffers fetched words in a small prefetch FIFO. Delivers {pc, instruction} pairs to decode over a valid/ready handshake. Supports branch/jump redirect with flush, and traps misaligned or out-of-range fetch addresses.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
MEM_BYTES, 1024, instruction memory size in bytes; a fetch is legal only if pc+3 < MEM_BYTES.
FIFO_DEPTH, 2, prefetch entries; power of two, at least 2.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
imem_addr  out  32  byte address to instruction memory; always equals the internal pc
imem_data  in  32  combinational read data {mem[a], mem[a+1], mem[a+2], mem[a+3]}
redirect_valid  in  1  branch/jump taken this cycle
redirect_pc  in  32  redirect target
out_valid  out  1  FIFO head valid
out_ready  in  1  decode accepts head
out_instr  out  32  head instruction
out_pc  out  32  head PC
fault  out  1  fetch fault, sticky
fault_pc  out  32  offending address

Behaviour:
- Reset (async): pc=RESET_PC, FIFO empty, state=FETCH, out_valid=0, fault=0, fault_pc=0. out_instr and out_pc read 0 while the FIFO is empty.
- States: FETCH and FAULT.
- FETCH, per clock edge:
  - push = (state==FETCH) && legal(pc) && (!full || pop) && !redirect_valid.
  - On push: write {pc, imem_data} at the tail and set pc=pc+4 (32-bit wrap, no carry-out).
  - pop = out_valid && out_ready.
  - Simultaneous push and pop with the FIFO full is allowed; occupancy is unchanged.
- Latency: the first out_valid is asserted 1 cycle after reset deasserts. Sustained throughput is 1 instruction/cycle while out_ready=1.
- Outputs out_instr, out_pc and out_valid come from registers/FIFO storage only, with no combinational path from out_ready.
- Full FIFO with no pop: pc holds and no memory word is captured.
- Redirect (either state) has priority over push and pop at the same edge:
  - FIFO is flushed.
  - out_valid=0 at the next cycle.
  - A handshake completing in the redirect cycle still counts as consumed by decode.
  - If redirect_pc[1:0]!=0 or redirect_pc+3 >= MEM_BYTES: state=FAULT, fault=1, fault_pc=redirect_pc.
  - Otherwise pc=redirect_pc and state=FETCH. In FAULT this also clears fault; fault_pc holds its value.
- Sequential fetch: if legal(pc) is false in FETCH (pc runs past MEM_BYTES-4), then state=FAULT, fault=1, fault_pc=pc. No push occurs.
- FAULT: no pushes; already-buffered entries still drain normally; pc holds. Exit only via a legal redirect or reset.
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for a clock edge.

Optional Feature:
- Macro: IFETCH_PERF_EN.
- When defined, adds three output ports, each 32 bits:
  - perf_fetched: push count.
  - perf_stall: cycles in FETCH with legal pc, FIFO full, and no pop.
  - perf_flush: number of redirects.
- All three counters reset to 0 and wrap on overflow.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package mips_pkg holds: IMEM_BYTES=1024, WORD_BYTES=4, an fetch_state_t enum {FETCH, FAULT}, and a fetch_entry_t struct {pc[31:0], instr[31:0]}.
- One sub-module is natural: ifetch_fifo, a synchronous FIFO of fetch_entry_t with flush, simultaneous push/pop when full, and full/empty flags.

Test Plan:
1. Memory preloaded with words 0x20080005, 0x20090003, 0x01095020, 0x00000000; hold out_ready=1 -> out_valid rises 1 cycle after reset; the beat sequence is (0x00, 0x20080005), (0x04, 0x20090003), (0x08, 0x01095020), one beat per cycle.
2. Hold out_ready=0 for 5 cycles -> exactly FIFO_DEPTH entries are buffered; imem_addr holds at 0x08; release out_ready -> PCs 0x00, 0x04, 0x08 in order with none lost or duplicated.
3. Redirect to 0x10 while the FIFO is full and out_ready=1 -> next cycle out_valid=0; following beats are 0x10, 0x14; entries 0x04 and 0x08 never appear.
4. Redirect to 0x102 -> fault=1, fault_pc=0x102, no further pushes; then redirect to 0x0 -> fault=0 and fetch resumes at 0x0.
5. Redirect to 0x3F8 -> beats 0x3F8 and 0x3FC, then fault=1, fault_pc=0x400.
6. Assert reset asynchronously between clock edges while mid-stream -> out_valid=0 and imem_addr=RESET_PC immediately; with IFETCH_PERF_EN defined, all three counters read 0.
